// File: rtl/head_stepper_if.sv
// Handshake bundle between the head stepper and its controller: run/period/direction
// requests in, stepped head position with a valid/ready handshake out.
interface head_stepper_if #(
   parameter int N  = 4,
   parameter int PW = 8
);
   logic          en;
   logic [PW-1:0] period;
   logic [1:0]    dir_in;
   logic          dir_valid;
   logic          step_ready;
   logic [N-1:0]  head_x;
   logic [N-1:0]  head_y;
   logic [1:0]    dir_out;
   logic          step_valid;

   modport master (
      output en, period, dir_in, dir_valid, step_ready,
      input  head_x, head_y, dir_out, step_valid
   );

   modport slave (
      input  en, period, dir_in, dir_valid, step_ready,
      output head_x, head_y, dir_out, step_valid
   );
endinterface

// File: rtl/head_stepper.sv
// Moves a head one cell per period on a 2^N x 2^N torus grid; each step is offered
// with step_valid and held until accepted, with non-reversing direction requests.
module head_stepper #(
   parameter int N       = 4,
   parameter int PW      = 8,
   parameter int START_X = 0,
   parameter int START_Y = 0
) (
   input logic           clk,
   input logic           rst,
   head_stepper_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   localparam logic [1:0] DIR_RIGHT = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;

   state_t        state, state_nxt;
   logic [PW-1:0] cnt, cnt_nxt, last;
   logic [N-1:0]  x, y, x_nxt, y_nxt;
   logic [1:0]    dir, dir_nxt, pend, pend_nxt;
   logic          counting;
   logic          step;

   // Encoding places opposite directions two apart, so the reverse is a flip of bit 1.
   function automatic logic [1:0] reverse(input logic [1:0] d);
      return d ^ 2'd2;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         x     <= N'(START_X);
         y     <= N'(START_Y);
         dir   <= DIR_RIGHT;
         pend  <= DIR_RIGHT;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
         dir   <= dir_nxt;
         pend  <= pend_nxt;
      end
   end

   // The acceptance edge also counts as a period cycle, so with step_ready held high
   // steps are exactly P cycles apart and period 0/1 steps every cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = x;
      y_nxt     = y;
      dir_nxt   = dir;
      pend_nxt  = pend;
      step      = 1'b0;
      last      = (bus.period == '0) ? '0 : bus.period - PW'(1);
      counting  = (state == RUN) || (state == HOLD && bus.step_ready);

      if (!bus.en) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: state_nxt = RUN;
            RUN, HOLD: begin
               if (counting) begin
                  if (cnt >= last) begin
                     step      = 1'b1;
                     cnt_nxt   = '0;
                     state_nxt = HOLD;
                  end else begin
                     cnt_nxt   = cnt + PW'(1);
                     state_nxt = RUN;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end

      if (step) begin
         dir_nxt = pend;
         case (pend)
            DIR_RIGHT: x_nxt = x + N'(1);
            DIR_DOWN:  y_nxt = y + N'(1);
            DIR_LEFT:  x_nxt = x - N'(1);
            default:   y_nxt = y - N'(1);
         endcase
      end

      // Reverse check uses the direction in force before this edge's step.
      if (bus.dir_valid && (bus.dir_in != reverse(dir))) begin
         pend_nxt = bus.dir_in;
      end
   end

   assign bus.head_x     = x;
   assign bus.head_y     = y;
   assign bus.dir_out    = dir;
   assign bus.step_valid = (state == HOLD);

endmodule

// File: tb/tb_head_stepper.sv
// Scoreboard bench: a cycle-level behavioural model predicts every step (position,
// direction, edge index); a negedge monitor checks each presented step against it.
module tb_head_stepper;
   localparam int N    = 4;
   localparam int PW   = 8;
   localparam int SX   = 3;
   localparam int SY   = 9;
   localparam int GRID = 1 << N;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   head_stepper_if #(.N(N), .PW(PW)) bus ();

   head_stepper #(.N(N), .PW(PW), .START_X(SX), .START_Y(SY)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int x;
      int y;
      int d;
      int at;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;

   // behavioural model state
   int m_x, m_y, m_dir, m_pend, m_ticks;
   bit m_active, m_wait;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edge_n);
      end
   endtask

   function automatic void model_reset();
      m_x = SX; m_y = SY; m_dir = 0; m_pend = 0;
      m_ticks = 0; m_active = 0; m_wait = 0;
   endfunction

   // Predict the outcome of the coming edge from the inputs now applied, then take it.
   task automatic tick();
      int  lim;
      bit  stepping;
      bit  take_dir;
      exp_t e;
      lim      = (bus.period == 0) ? 1 : int'(bus.period);
      stepping = 0;
      take_dir = bus.dir_valid && (int'(bus.dir_in) != (m_dir + 2) % 4);
      if (!bus.en) begin
         m_active = 0;
         m_wait   = 0;
      end else if (!m_active) begin
         m_active = 1;
      end else if (!m_wait || bus.step_ready) begin
         m_ticks++;
         m_wait = 0;
         if (m_ticks >= lim) begin
            stepping = 1;
            m_ticks  = 0;
            m_wait   = 1;
         end
      end
      if (stepping) begin
         m_dir = m_pend;
         case (m_dir)
            0: m_x = (m_x + 1) % GRID;
            1: m_y = (m_y + 1) % GRID;
            2: m_x = (m_x + GRID - 1) % GRID;
            default: m_y = (m_y + GRID - 1) % GRID;
         endcase
         e.x = m_x; e.y = m_y; e.d = m_dir; e.at = edge_n + 1;
         q.push_back(e);
      end
      if (take_dir) m_pend = int'(bus.dir_in);
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", int'(bus.step_valid), 0);
      chk("rst_x", int'(bus.head_x), SX);
      chk("rst_y", int'(bus.head_y), SY);
      chk("rst_dir", int'(bus.dir_out), 0);
      model_reset();
      q.delete();
      @(posedge clk);
      edge_n++;
      #1;
      rst = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_dir(input int d);
      bus.dir_in    = 2'(d);
      bus.dir_valid = 1'b1;
      tick();
      bus.dir_valid = 1'b0;
   endtask

   // monitor: a new step is presented when valid rises or the previous one was accepted
   bit prev_v = 0;
   bit prev_r = 0;
   int last_x, last_y, last_d;
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.step_valid) begin
         if (!prev_v || prev_r) begin
            if (q.size() == 0) begin
               chk("unexpected_step", 1, 0);
            end else begin
               e = q.pop_front();
               chk("step_edge", edge_n, e.at);
               chk("step_x", int'(bus.head_x), e.x);
               chk("step_y", int'(bus.head_y), e.y);
               chk("step_dir", int'(bus.dir_out), e.d);
            end
            last_x = int'(bus.head_x);
            last_y = int'(bus.head_y);
            last_d = int'(bus.dir_out);
         end else begin
            chk("stall_x", int'(bus.head_x), last_x);
            chk("stall_y", int'(bus.head_y), last_y);
            chk("stall_dir", int'(bus.dir_out), last_d);
         end
      end
      prev_v = bus.step_valid;
      prev_r = bus.step_ready;
   end

   initial begin
      bus.en         = 1'b0;
      bus.period     = 8'd3;
      bus.dir_in     = 2'd0;
      bus.dir_valid  = 1'b0;
      bus.step_ready = 1'b1;
      rst            = 1'b0;
      model_reset();
      #2;
      apply_reset();

      // basic stepping, then a stall
      bus.en = 1'b1;
      ticks(10);
      bus.step_ready = 1'b0;
      ticks(8);
      bus.step_ready = 1'b1;
      ticks(6);

      // reverse rejection, then DOWN followed by LEFT between steps
      pulse_dir(2);
      ticks(4);
      pulse_dir(1);
      pulse_dir(2);
      ticks(8);
      pulse_dir(2);
      ticks(6);

      // period 0 with wrap-around going left, then up
      bus.period = 8'd0;
      ticks(20);
      pulse_dir(3);
      ticks(20);

      // en drop mid-count and mid-hold
      bus.period = 8'd4;
      ticks(2);
      bus.en = 1'b0;
      ticks(3);
      bus.en = 1'b1;
      bus.step_ready = 1'b0;
      ticks(8);
      bus.en = 1'b0;
      ticks(2);
      bus.en = 1'b1;
      bus.step_ready = 1'b1;
      ticks(4);

      // reset while a step is held
      bus.period = 8'd2;
      bus.step_ready = 1'b0;
      for (int i = 0; i < 20 && !bus.step_valid; i++) tick();
      chk("reach_hold", int'(bus.step_valid), 1);
      pulse_dir(1);
      apply_reset();
      bus.step_ready = 1'b1;
      ticks(10);

      // randomized run
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            apply_reset();
         end else begin
            bus.en         = ($urandom_range(0, 24) != 0);
            bus.step_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) bus.period = 8'($urandom_range(0, 5));
            bus.dir_valid  = ($urandom_range(0, 3) == 0);
            bus.dir_in     = 2'($urandom_range(0, 3));
            tick();
         end
      end
      bus.dir_valid = 1'b0;
      #6;
      chk("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/head_stepper.md
HEAD_STEPPER -- requirements
Module: head_stepper

Interface
REQ-001 Parameter N, default 4: coordinate width; grid is 2^N x 2^N cells.
REQ-002 Parameter PW, default 8: width of step-period counter.
REQ-003 Parameter START_X, default 0: head x coordinate after reset.
REQ-004 Parameter START_Y, default 0: head y coordinate after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 en  input  1  run enable; low freezes the counter and holds position.
REQ-008 period  input  PW  clock cycles per step; 0 is treated as 1.
REQ-009 dir_in  input  2  requested direction: 0=RIGHT, 1=DOWN, 2=LEFT, 3=UP.
REQ-010 dir_valid  input  1  qualifies dir_in for one cycle.
REQ-011 step_ready  input  1  downstream accepts the current step.
REQ-012 head_x  output  N  current head x coordinate.
REQ-013 head_y  output  N  current head y coordinate.
REQ-014 dir_out  output  2  direction applied at the last step.
REQ-015 step_valid  output  1  new head position available; held until accepted.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HOLD.
REQ-017 IDLE->RUN when en=1; RUN->IDLE and HOLD->IDLE when en=0.
REQ-018 A step completed before en falls SHALL remain in head_x/head_y; step_valid drops in IDLE.
REQ-019 In RUN the counter SHALL increment each cycle.
REQ-020 When the counter reaches max(period,1)-1, the following edge SHALL clear the counter, update the position and enter HOLD.
REQ-021 With period=P (P>=1), the first step after entering RUN SHALL occur P cycles after RUN entry, and then every P cycles plus stall cycles.
REQ-022 step_valid SHALL be 1 exactly while in HOLD.
REQ-023 HOLD->RUN SHALL occur on the edge where step_valid=1 and step_ready=1; head_x, head_y and dir_out SHALL stay stable throughout HOLD.
REQ-024 The counter SHALL be frozen in HOLD and IDLE; no step is lost or merged during a stall.
REQ-025 A dir_valid=1 cycle in any state SHALL load dir_in into a pending-direction register.
REQ-026 A request for the exact reverse of dir_out (RIGHT<->LEFT, UP<->DOWN) SHALL be ignored.
REQ-027 If several dir_valid pulses arrive between steps, the last non-reverse request wins.
REQ-028 At a step, dir_out SHALL take the pending direction, and the move SHALL use the new direction.
REQ-029 Moves: RIGHT x+1, LEFT x-1, DOWN y+1, UP y-1; all arithmetic is modulo 2^N.
REQ-030 Wrap-around: x=2^N-1 moving RIGHT gives x=0; x=0 moving LEFT gives x=2^N-1; y wraps the same way.
REQ-031 dir_valid on the same edge as a step SHALL be compared against the pre-step dir_out; the pending register is updated and the request takes effect at the next step.
REQ-032 A change of period takes effect immediately; if the counter is already >= the new period-1, the step SHALL occur on the next edge.

Reset
REQ-033 While rst=1 the block SHALL be in IDLE with counter=0, head_x=START_X, head_y=START_Y, dir_out=RIGHT, pending direction=RIGHT and step_valid=0, independent of clk.
REQ-034 rst asserted mid-HOLD or mid-count SHALL drop step_valid immediately (asynchronously) and discard any pending direction.
REQ-035 After rst deasserts, the first step SHALL need a full period count from 0.

Verification
REQ-036 Basic step: reset, en=1, period=3, step_ready=1 -> step_valid is a one-cycle pulse every 3 cycles; head_x = 1, 2, 3; head_y=0.
REQ-037 Stall: step_ready=0 for 5 cycles after step_valid -> head_x, head_y and dir_out stay stable, the counter is frozen, and the next step comes 3 cycles after acceptance.
REQ-038 Wrap: N=4, head at x=15, dir RIGHT -> next step gives x=0; from y=0, set UP -> y=15.
REQ-039 Reverse rejection: dir_out=RIGHT, dir_valid with LEFT -> the next step still moves RIGHT; DOWN then LEFT between steps -> moves DOWN, then LEFT is accepted at later steps.
REQ-040 period=0 -> a step every cycle while step_ready=1.
REQ-041 Reset: assert rst during HOLD at head (5,7) -> step_valid=0 at once; head returns to (START_X,START_Y) and dir_out=RIGHT.
